sha256_msg_loader: RTL and testbench
====================================

# sha256_msg_loader

Host-side front end for `simplified_sha256`. It accepts `NUM_OF_WORDS` raw 32-bit message words over a valid/ready stream and writes them into shared word-addressed memory at `input_addr`. It appends standard SHA-256 padding, pulses the hasher's `start`, and waits for completion. It then reads the 8-word digest back from `hash_addr` and presents it as one 256-bit result.

## Interface
- `NUM_OF_WORDS`, default 40: message length in 32-bit words; must match the hasher instance.
- `clk` in 1: single clock, also drives memory.
- `rst` in 1: synchronous, active-high reset.
- `go` in 1: one-cycle request to begin; ignored unless in IDLE.
- `input_addr`, `hash_addr` in 16: word addresses; sampled on accepted `go`.
- `msg_valid` in 1, `msg_data` in 32, `msg_ready` out 1: message stream; a word transfers when valid&&ready.
- `mem_addr` out 16, `mem_wdata` out 32, `mem_we` out 1: memory request.
- `mem_rdata` in 32: read data, valid one cycle after the address.
- `bus_own` out 1: high while the loader drives memory; the top level muxes the memory port to the hasher when low.
- `sha_start` out 1, `sha_done` in 1: hasher handshake.
- `digest` out 256, `digest_valid` out 1: result, word 0 in bits [255:224].
- `busy` out 1: high in any state other than IDLE.

## Operation
- Padded length: `P = 16*ceil((N+3)/16)` words, where N=`NUM_OF_WORDS`.
  - Word N = 32'h80000000.
  - Words N+1..P-3 = 0.
  - Word P-2 = 0.
  - Word P-1 = N*32, truncated to 32 bits.
- States and transitions:
  - IDLE: on `go`, latch addresses, clear word counter, go to LOAD.
  - LOAD: `msg_ready`=1. Each transfer writes `msg_data` to `input_addr+cnt` with `mem_we`=1 in the same cycle. After N transfers, go to PAD.
  - PAD: one padding word written per cycle at `input_addr+cnt` until `cnt==P-1` is written, then go to KICK.
  - KICK: `sha_start`=1 for exactly one cycle, `bus_own`=0, go to WAIT_LOW.
  - WAIT_LOW: wait for `sha_done`=0, meaning the hasher has left its IDLE state, then go to WAIT_DONE.
  - WAIT_DONE: wait for `sha_done`=1, then go to RD.
  - RD: issue reads at `hash_addr+0..7` on consecutive cycles. Capture `mem_rdata` one cycle later into digest word i. After the eighth capture, go to OUT.
  - OUT: `digest_valid`=1 for one cycle, then go to IDLE.
- `bus_own`=1 in LOAD, PAD, and RD, and 0 elsewhere.
- `mem_we`=1 only on LOAD transfer cycles and PAD cycles.
- Counters are 16 bits wide. Address sums wrap modulo 2^16.

## Timing
- Reset values: state IDLE; `msg_ready`, `mem_we`, `sha_start`, `digest_valid`, `bus_own`, `busy` = 0; `mem_addr`, `mem_wdata`, `digest` = 0.
- `go` at cycle 0 puts the block in LOAD at cycle 1.
- With `msg_valid` held high, LOAD lasts N cycles and PAD lasts P-N cycles, followed by one KICK cycle.
- RD lasts 9 cycles: 8 address cycles plus a final capture cycle. `digest_valid` follows 1 cycle later.
- Back-pressure: a `msg_valid`=0 cycle in LOAD stalls with no write.
- `go` while `busy`: ignored.
- `msg_valid` outside LOAD: not accepted, since `msg_ready`=0.
- `sha_done` already 1 in KICK: WAIT_LOW must still see it drop before WAIT_DONE. There is no timeout.
- `rst` mid-operation: next cycle is IDLE with all outputs at reset values. Memory contents written so far are left as is.
- `digest` holds its value until the next accepted `go`.

## Structure
- Shared package `sha256_pkg` holds:
  - the state enum;
  - `PAD_WORD` = 32'h80000000;
  - function `padded_words(n)`, returning P;
  - function `num_blocks(n)`, returning P/16.
- The hasher's block-count logic reuses the same package functions.
- One sub-module, `sha256_pad_word`, is natural: combinational, maps (index, N) to the padding word value.
- Everything else lives in a single FSM module.

## Test plan
- N=40, stream words 0..39 back to back:
  - memory[input_addr+0..39] = data;
  - [+40] = 80000000;
  - [+41..46] = 0;
  - [+47] = 00000500;
  - one `sha_start` pulse.
- N=13: P=16, [+13]=80000000, [+15]=000001A0. N=14: P=32, [+31]=000001C0.
- `msg_valid` toggled every other cycle with N=40: 40 correct writes, no duplicates, and `mem_we` is low on stall cycles.
- Hasher model drops `sha_done` 3 cycles after start and raises it 100 cycles later, with memory[hash_addr+i]=32'h1111_1111*(i+1):
  - `digest` = 11111111_22222222_…_88888888;
  - `digest_valid` is high for exactly 1 cycle.
- Assert `rst` during PAD, then `go`: the block restarts at LOAD, counter is 0, and there is no `sha_start` before the new PAD completes.
- `go` pulsed during WAIT_DONE: ignored, and `digest` is unchanged until completion.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 host loader and hasher: FSM encoding,
// the padding marker word and the padded-length helpers.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PAD       = 3'd2,
        ST_KICK      = 3'd3,
        ST_WAIT_LOW  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_RD        = 3'd6,
        ST_OUT       = 3'd7
    } state_t;

    localparam logic [31:0] PAD_WORD     = 32'h8000_0000;
    localparam int          DIGEST_WORDS = 8;
    localparam int          BLOCK_WORDS  = 16;

    // Message plus marker word plus 64-bit length, rounded up to whole 512-bit blocks.
    function automatic int padded_words(input int n);
        return BLOCK_WORDS * ((n + 3 + BLOCK_WORDS - 1) / BLOCK_WORDS);
    endfunction

    function automatic int num_blocks(input int n);
        return padded_words(n) / BLOCK_WORDS;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Padding word generator: maps a padded-message word index to the value that
// belongs there once the raw message has been loaded.
module sha256_pad_word
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 40
) (
    input  logic [15:0] index,
    output logic [31:0] word
);

    localparam logic [15:0] MARKER_IDX = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LENGTH_IDX = 16'(padded_words(NUM_OF_WORDS) - 1);
    localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);

    // NOTE: the default assignment ahead of the if-chain keeps this purely
    // combinational; leaving any path unassigned would infer a latch.
    always_comb begin
        word = '0;
        if (index == MARKER_IDX) begin
            word = PAD_WORD;
        end else if (index == LENGTH_IDX) begin
            word = BIT_LEN;
        end
    end

endmodule

// File: rtl/sha256_msg_loader.sv
// Host front end for the hasher: streams the message into shared memory,
// appends padding, kicks the hasher and reads the 256-bit digest back.
module sha256_msg_loader
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [15:0]  input_addr,
    input  logic [15:0]  hash_addr,
    input  logic         msg_valid,
    input  logic [31:0]  msg_data,
    output logic         msg_ready,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         mem_we,
    input  logic [31:0]  mem_rdata,
    output logic         bus_own,
    output logic         sha_start,
    input  logic         sha_done,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    localparam logic [15:0] LAST_MSG = 16'(NUM_OF_WORDS - 1);
    localparam logic [15:0] LAST_PAD = 16'(padded_words(NUM_OF_WORDS) - 1);
    localparam logic [15:0] LAST_RD  = 16'(DIGEST_WORDS);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] in_base;
    logic [15:0] hash_base;
    logic [31:0] dig_w [DIGEST_WORDS];
    logic [31:0] pad_data;
    logic [2:0]  cap_idx;

    sha256_pad_word #(
        .NUM_OF_WORDS(NUM_OF_WORDS)
    ) u_pad_word (
        .index(cnt),
        .word (pad_data)
    );

    // Read data arrives one cycle after its address, so capture lags the counter by one.
    assign cap_idx = cnt[2:0] - 3'd1;

    assign msg_ready    = (state == ST_LOAD);
    assign sha_start    = (state == ST_KICK);
    assign digest_valid = (state == ST_OUT);
    assign busy         = (state != ST_IDLE);
    assign bus_own      = (state == ST_LOAD) || (state == ST_PAD) || (state == ST_RD);

    assign digest = {dig_w[0], dig_w[1], dig_w[2], dig_w[3],
                     dig_w[4], dig_w[5], dig_w[6], dig_w[7]};

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            ST_LOAD: begin
                mem_addr  = in_base + cnt;
                mem_wdata = msg_data;
                mem_we    = msg_valid;
            end
            ST_PAD: begin
                mem_addr  = in_base + cnt;
                mem_wdata = pad_data;
                mem_we    = 1'b1;
            end
            ST_RD: begin
                mem_addr = hash_base + cnt;
            end
            default: begin
            end
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_base   <= '0;
            hash_base <= '0;
            // NOTE: the digest words are a small register file, not RAM; they
            // are reset only because a zero digest is visible at the port.
            for (int i = 0; i < DIGEST_WORDS; i++) begin
                dig_w[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        in_base   <= input_addr;
                        hash_base <= hash_addr;
                        cnt       <= '0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (msg_valid) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == LAST_MSG) begin
                            state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == LAST_PAD) begin
                        state <= ST_KICK;
                    end
                end
                ST_KICK: begin
                    state <= ST_WAIT_LOW;
                end
                // A stale done from the previous run must drop before completion counts.
                ST_WAIT_LOW: begin
                    if (!sha_done) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (sha_done) begin
                        cnt   <= '0;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (cnt != 16'd0) begin
                        dig_w[cap_idx] <= mem_rdata;
                    end
                    cnt <= cnt + 16'd1;
                    if (cnt == LAST_RD) begin
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Scoreboard bench for sha256_msg_loader: memory and hasher models around an
// N=40 instance plus two small instances exercising the padding block boundary.
module tb_sha256_msg_loader;

    localparam int N = 40;
    localparam logic [255:0] DIGEST_BASE =
        256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [15:0]  input_addr = '0;
    logic [15:0]  hash_addr = '0;
    logic         msg_valid = 1'b0;
    logic [31:0]  msg_data = '0;
    logic         msg_ready;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic [31:0]  mem_rdata;
    logic         bus_own;
    logic         sha_start;
    logic         sha_done;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    // Small instances share a constant message stream.
    logic         go_s = 1'b0;
    logic         msg_valid_s = 1'b0;
    logic         rdy13, we13, own13, start13, dv13, busy13;
    logic         rdy14, we14, own14, start14, dv14, busy14;
    logic [15:0]  addr13, addr14;
    logic [31:0]  wdata13, wdata14;
    logic [255:0] dig13, dig14;

    // Hasher model port and memory.
    logic         h_we;
    logic [15:0]  h_addr;
    logic [31:0]  h_wdata;
    logic [15:0]  h_base = '0;
    logic [31:0]  h_xor = '0;
    logic [31:0]  mem [65536];
    logic [15:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_we;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_starts = 0;
    int done_cyc = 0;
    int load_cycles = 0;
    int pad_cycles = 0;
    logic prev_dv = 1'b0;

    wr_t          wq[$];
    logic [255:0] dq[$];

    always #5 clk = ~clk;

    sha256_msg_loader #(.NUM_OF_WORDS(N)) dut (
        .clk(clk), .rst(rst), .go(go), .input_addr(input_addr), .hash_addr(hash_addr),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .bus_own(bus_own), .sha_start(sha_start), .sha_done(sha_done),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    sha256_msg_loader #(.NUM_OF_WORDS(13)) dut13 (
        .clk(clk), .rst(rst), .go(go_s), .input_addr(16'h0100), .hash_addr(16'h0000),
        .msg_valid(msg_valid_s), .msg_data(32'h5A5A_5A5A), .msg_ready(rdy13),
        .mem_addr(addr13), .mem_wdata(wdata13), .mem_we(we13), .mem_rdata(32'h0),
        .bus_own(own13), .sha_start(start13), .sha_done(1'b1),
        .digest(dig13), .digest_valid(dv13), .busy(busy13)
    );

    sha256_msg_loader #(.NUM_OF_WORDS(14)) dut14 (
        .clk(clk), .rst(rst), .go(go_s), .input_addr(16'h0100), .hash_addr(16'h0000),
        .msg_valid(msg_valid_s), .msg_data(32'h5A5A_5A5A), .msg_ready(rdy14),
        .mem_addr(addr14), .mem_wdata(wdata14), .mem_we(we14), .mem_rdata(32'h0),
        .bus_own(own14), .sha_start(start14), .sha_done(1'b1),
        .digest(dig14), .digest_valid(dv14), .busy(busy14)
    );

    // Shared memory: loader owns the port when bus_own is high, hasher otherwise.
    assign m_addr  = bus_own ? mem_addr  : h_addr;
    assign m_wdata = bus_own ? mem_wdata : h_wdata;
    assign m_we    = bus_own ? mem_we    : h_we;

    always @(posedge clk) begin
        mem_rdata <= mem[m_addr];
        if (m_we) mem[m_addr] <= m_wdata;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Hasher model: done drops 3 cycles after start, digest written, done back ~100 cycles later.
    initial begin
        sha_done = 1'b1;
        h_we = 1'b0;
        h_addr = '0;
        h_wdata = '0;
        forever begin
            @(negedge clk);
            if (sha_start) begin
                n_starts++;
                repeat (3) @(posedge clk);
                #1 sha_done = 1'b0;
                repeat (90) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    #1;
                    h_we = 1'b1;
                    h_addr = h_base + 16'(i);
                    h_wdata = 32'(32'h1111_1111 * (i + 1)) ^ h_xor;
                    @(posedge clk);
                end
                #1 h_we = 1'b0;
                repeat (2) @(posedge clk);
                #1 sha_done = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    // Write scoreboard for the N=40 instance.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (msg_ready) load_cycles++;
            if (bus_own && mem_we && !msg_ready) pad_cycles++;
            if (mem_we && !bus_own) begin
                n_checks++;
                n_errors++;
                $display("FAIL we_without_bus: mem_we=1 with bus_own=0");
            end
            if (msg_ready && !msg_valid) begin
                n_checks++;
                if (mem_we !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_we: mem_we=%b on stall cycle, required 0", mem_we);
                end
            end
            if (mem_we && bus_own) begin
                n_checks++;
                if (wq.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h, no write expected", mem_addr, mem_wdata);
                end else begin
                    e = wq.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        n_errors++;
                        $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Digest scoreboard: value, single-cycle strobe and latency from sha_done rising.
    initial begin
        logic [255:0] e;
        forever begin
            @(negedge clk);
            if (prev_dv) begin
                n_checks++;
                if (digest_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL dv_width: digest_valid=%b on second cycle, required 0", digest_valid);
                end
            end
            if (digest_valid === 1'b1) begin
                n_checks++;
                if (dq.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_digest: digest_valid with no digest expected");
                end else begin
                    e = dq.pop_front();
                    if (digest !== e) begin
                        n_errors++;
                        $display("FAIL digest: got %h, required %h", digest, e);
                    end
                end
                n_checks++;
                if (cyc - done_cyc != 10) begin
                    n_errors++;
                    $display("FAIL digest_latency: %0d cycles after done, required 10", cyc - done_cyc);
                end
            end
            prev_dv = digest_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic pulse_go(input logic [15:0] ia, input logic [15:0] ha);
        input_addr = ia;
        hash_addr = ha;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] addr, input logic [31:0] d);
        logic ok;
        int t;
        ok = 1'b0;
        t = 0;
        wq.push_back({addr, d});
        msg_valid = 1'b1;
        msg_data = d;
        while (!ok && t < 20) begin
            @(negedge clk);
            ok = msg_ready;
            @(posedge clk);
            #1;
            t++;
        end
        msg_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL send_timeout: msg_ready=0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic push_pads(input logic [15:0] base);
        wq.push_back({base + 16'd40, 32'h8000_0000});
        for (int k = 41; k <= 46; k++) wq.push_back({base + 16'(k), 32'h0000_0000});
        wq.push_back({base + 16'd47, 32'h0000_0500});
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({msg_ready, mem_we, sha_start, digest_valid, bus_own, busy} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {msg_ready, mem_we, sha_start, digest_valid, bus_own, busy});
        end
        n_checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mem: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (digest !== 256'h0) begin
            n_errors++;
            $display("FAIL reset_digest: got %h, required 0", digest);
        end
    endtask

    task automatic test_pad_boundaries;
        int c13, c14, s13, s14;
        logic [15:0] idx;
        logic [31:0] exp_w;
        c13 = 0; c14 = 0; s13 = 0; s14 = 0;
        go_s = 1'b1;
        @(posedge clk);
        #1 go_s = 1'b0;
        msg_valid_s = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (we13) begin
                idx = addr13 - 16'h0100;
                exp_w = (idx < 16'd13) ? 32'h5A5A_5A5A :
                        (idx == 16'd13) ? 32'h8000_0000 :
                        (idx == 16'd15) ? 32'h0000_01A0 : 32'h0;
                n_checks++;
                if (wdata13 !== exp_w) begin
                    n_errors++;
                    $display("FAIL pad13[%0d]: got %h, required %h", idx, wdata13, exp_w);
                end
                c13++;
            end
            if (we14) begin
                idx = addr14 - 16'h0100;
                exp_w = (idx < 16'd14) ? 32'h5A5A_5A5A :
                        (idx == 16'd14) ? 32'h8000_0000 :
                        (idx == 16'd31) ? 32'h0000_01C0 : 32'h0;
                n_checks++;
                if (wdata14 !== exp_w) begin
                    n_errors++;
                    $display("FAIL pad14[%0d]: got %h, required %h", idx, wdata14, exp_w);
                end
                c14++;
            end
            if (start13) s13++;
            if (start14) s14++;
        end
        msg_valid_s = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (c13 != 16 || c14 != 32) begin
            n_errors++;
            $display("FAIL pad_len: got %0d/%0d writes, required 16/32", c13, c14);
        end
        n_checks++;
        if (s13 != 1 || s14 != 1) begin
            n_errors++;
            $display("FAIL pad_start: got %0d/%0d start pulses, required 1/1", s13, s14);
        end
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = n_starts;
        load_cycles = 0;
        pad_cycles = 0;
        h_base = 16'h2000;
        h_xor = 32'h0;
        pulse_go(16'h1000, 16'h2000);
        n_checks++;
        if (msg_ready !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL load_entry: ready=%b busy=%b, required 1 1", msg_ready, busy);
        end
        for (int i = 0; i < N; i++) send_word(16'h1000 + 16'(i), $urandom());
        push_pads(16'h1000);
        dq.push_back(DIGEST_BASE);
        wait_idle(400, "b2b");
        n_checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_pending: %0d writes, %0d digests outstanding, required 0", wq.size(), dq.size());
        end
        n_checks++;
        if (load_cycles != 40 || pad_cycles != 8) begin
            n_errors++;
            $display("FAIL b2b_phases: load=%0d pad=%0d cycles, required 40 8", load_cycles, pad_cycles);
        end
        n_checks++;
        if (n_starts - s0 != 1) begin
            n_errors++;
            $display("FAIL b2b_start: %0d start pulses, required 1", n_starts - s0);
        end
        n_checks++;
        if (digest !== DIGEST_BASE) begin
            n_errors++;
            $display("FAIL b2b_hold: digest=%h, required %h", digest, DIGEST_BASE);
        end
    endtask

    task automatic test_backpressure_ignored_go;
        logic [15:0] base;
        logic [255:0] exp_d;
        int t;
        base = 16'hFFE8;
        h_base = 16'h3000;
        h_xor = 32'h0F0F_0F0F;
        exp_d = DIGEST_BASE ^ {8{32'h0F0F_0F0F}};
        pulse_go(base, 16'h3000);
        for (int i = 0; i < N; i++) begin
            send_word(base + 16'(i), $urandom());
            if (i != N - 1) begin
                @(posedge clk);
                #1;
            end
        end
        push_pads(base);
        dq.push_back(exp_d);
        t = 0;
        while (sha_done !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (sha_done !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_done_low_timeout: sha_done=%b, required 0", sha_done);
        end
        repeat (5) @(posedge clk);
        #1;
        pulse_go(16'h0000, 16'h4000);
        n_checks++;
        if (busy !== 1'b1 || msg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ignored_go: busy=%b ready=%b, required 1 0", busy, msg_ready);
        end
        n_checks++;
        if (digest !== DIGEST_BASE) begin
            n_errors++;
            $display("FAIL digest_hold: got %h, required %h", digest, DIGEST_BASE);
        end
        wait_idle(400, "bp");
        n_checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            n_errors++;
            $display("FAIL bp_pending: %0d writes, %0d digests outstanding, required 0", wq.size(), dq.size());
        end
        n_checks++;
        if (digest !== exp_d) begin
            n_errors++;
            $display("FAIL bp_digest_final: got %h, required %h", digest, exp_d);
        end
    endtask

    task automatic test_reset_mid_pad;
        int s0;
        int t;
        h_base = 16'h2000;
        h_xor = 32'h0;
        pulse_go(16'h0500, 16'h2000);
        for (int i = 0; i < N; i++) send_word(16'h0500 + 16'(i), $urandom());
        push_pads(16'h0500);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({msg_ready, mem_we, sha_start, digest_valid, bus_own, busy} !== 6'b0) begin
            n_errors++;
            $display("FAIL midrst_ctrl: got %b, required 000000",
                     {msg_ready, mem_we, sha_start, digest_valid, bus_own, busy});
        end
        n_checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 32'h0 || digest !== 256'h0) begin
            n_errors++;
            $display("FAIL midrst_data: addr=%h wdata=%h digest=%h, required 0", mem_addr, mem_wdata, digest);
        end
        wq.delete();
        s0 = n_starts;
        pulse_go(16'h0600, 16'h2000);
        n_checks++;
        if (msg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_restart: msg_ready=%b, required 1", msg_ready);
        end
        for (int i = 0; i < N; i++) send_word(16'h0600 + 16'(i), $urandom());
        push_pads(16'h0600);
        dq.push_back(DIGEST_BASE);
        t = 0;
        while (wq.size() != 0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (wq.size() != 0 || n_starts != s0) begin
            n_errors++;
            $display("FAIL midrst_early_start: %0d writes left, %0d starts, required 0 0", wq.size(), n_starts - s0);
        end
        wait_idle(400, "midrst");
        n_checks++;
        if (dq.size() != 0 || n_starts != s0 + 1) begin
            n_errors++;
            $display("FAIL midrst_complete: %0d digests left, %0d starts, required 0 1", dq.size(), n_starts - s0);
        end
    endtask

    initial begin
        test_reset();
        test_pad_boundaries();
        test_back_to_back();
        test_backpressure_ignored_go();
        test_reset_mid_pad();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
